// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter.
// Build option: define UART_TX_PARITY_EN to add a parity bit after the payload.
package uart_pkg;

   // Values accepted by the PARITY_ODD parameter.
   localparam int unsigned ParityEven = 0;
   localparam int unsigned ParityOdd  = 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} tx_state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: tick is high in the last cycle of every bit period.
// clear holds the count at zero so each frame starts a fresh bit period.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear,
   output logic tick
);

   localparam int unsigned     CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // With CLKS_PER_BIT=1 the count stays at zero and tick is permanently high.
   assign tick = (cnt_q == CntMax);

   // Next count: wrap at the end of a bit period or when cleared.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   // Cycle counter within the current bit period.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start bit, DATA_W bits LSB first, optional parity,
// STOP_BITS stop bits. ready/tx/busy are all registered.
// Build option: define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy
);

   localparam int unsigned        BitCntW  = $clog2(DATA_W);
   localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DATA_W - 1);
   localparam logic               LastStop = 1'(STOP_BITS - 1);

   if (DATA_W < 5 || DATA_W > 9) begin : gen_bad_data_w
      $error("uart_tx_framed: DATA_W must be 5..9");
   end
   if (CLKS_PER_BIT < 1) begin : gen_bad_clks_per_bit
      $error("uart_tx_framed: CLKS_PER_BIT must be at least 1");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
      $error("uart_tx_framed: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD != ParityEven && PARITY_ODD != ParityOdd) begin : gen_bad_parity_odd
      $error("uart_tx_framed: PARITY_ODD must be 0 or 1");
   end

   tx_state_e          state_q;
   logic [DATA_W-1:0]  shift_q;
   logic [BitCntW-1:0] bit_cnt_q;
   logic               stop_cnt_q;
   logic               ready_q;
   logic               tx_q;
   logic               busy_q;
   logic               bit_tick;
   logic               baud_clear;
`ifdef UART_TX_PARITY_EN
   logic               par_q;
`endif

   assign ready = ready_q;
   assign tx    = tx_q;
   assign busy  = busy_q;

   // Divider runs only inside a frame, so every frame starts on a full bit period.
   assign baud_clear = (state_q == StIdle);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .CLK  (CLK),
      .RESET(RESET),
      .clear(baud_clear),
      .tick (bit_tick)
   );

   // Frame sequencer; tx is updated on the same edge as the state so it is never decoded.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= StIdle;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         ready_q    <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               ready_q <= 1'b1;
               if (valid && ready_q) begin
                  shift_q    <= data;
                  bit_cnt_q  <= '0;
                  stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_q      <= (^data) ^ (PARITY_ODD == ParityOdd);
`endif
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  tx_q       <= 1'b0;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               if (bit_tick) begin
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  state_q <= StData;
               end
            end
            StData: begin
               if (bit_tick) begin
                  if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                     tx_q    <= par_q;
                     state_q <= StParity;
`else
                     tx_q    <= 1'b1;
                     state_q <= StStop;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_tick) begin
                  tx_q    <= 1'b1;
                  state_q <= StStop;
               end
            end
`endif
            StStop: begin
               if (bit_tick) begin
                  if (stop_cnt_q == LastStop) begin
                     state_q <= StIdle;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     tx_q    <= 1'b1;
                  end else begin
                     stop_cnt_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: four instances cover default, two stop bits,
// CLKS_PER_BIT=1 with 5-bit payload, and odd parity.
module tb_uart_tx_framed;

`ifdef UART_TX_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif
   localparam int P = int'(ParEn);

   typedef struct {
      logic tx;
      logic busy;
      logic ready;
   } exp_t;

   // bits: expected tx level per bit period, bit 0 sent first.
   typedef struct {
      int         k;
      logic [8:0] d;
      logic [15:0] bits;
      int         nbits;
      bit         toggle;
   } vec_t;

   logic            CLK   = 1'b0;
   logic            RESET = 1'b0;
   logic [3:0][8:0] data  = '0;
   logic [3:0]      valid = '0;
   logic [3:0]      ready, tx, busy;

   exp_t exp_q[$];
   vec_t vecs[8];
   int   cur;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 CLK = ~CLK;

   uart_tx_framed u_dut0 (
      .CLK(CLK), .RESET(RESET), .data(data[0][7:0]), .valid(valid[0]),
      .ready(ready[0]), .tx(tx[0]), .busy(busy[0])
   );
   uart_tx_framed #(.STOP_BITS(2)) u_dut1 (
      .CLK(CLK), .RESET(RESET), .data(data[1][7:0]), .valid(valid[1]),
      .ready(ready[1]), .tx(tx[1]), .busy(busy[1])
   );
   uart_tx_framed #(.DATA_W(5), .CLKS_PER_BIT(1)) u_dut2 (
      .CLK(CLK), .RESET(RESET), .data(data[2][4:0]), .valid(valid[2]),
      .ready(ready[2]), .tx(tx[2]), .busy(busy[2])
   );
   uart_tx_framed #(.PARITY_ODD(1)) u_dut3 (
      .CLK(CLK), .RESET(RESET), .data(data[3][7:0]), .valid(valid[3]),
      .ready(ready[3]), .tx(tx[3]), .busy(busy[3])
   );

   function automatic int cpb_of(input int k);
      return (k == 2) ? 1 : 4;
   endfunction

   task automatic check(input string name, input logic act, input logic req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t: got %b, expected %b", name, cur, $time, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_assert++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, cur, $time, act, req);
      end
   endtask

   // Expected per-cycle outputs of one frame followed by its idle cycle.
   task automatic push_frame(input logic [15:0] bits, input int nbits, input int cpb);
      exp_t e;
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < cpb; c++) begin
            e.tx = bits[i]; e.busy = 1'b1; e.ready = 1'b0;
            exp_q.push_back(e);
         end
      end
      e.tx = 1'b1; e.busy = 1'b0; e.ready = 1'b1;
      exp_q.push_back(e);
   endtask

   // Advance to the next falling edge and score one expected cycle.
   task automatic step();
      exp_t e;
      @(negedge CLK);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("tx", tx[cur], e.tx);
         check("busy", busy[cur], e.busy);
         check("ready", ready[cur], e.ready);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      n   = v.nbits * cpb_of(v.k) + 1;
      cur = v.k;
      push_frame(v.bits, v.nbits, cpb_of(v.k));
      data[v.k]  = v.d;
      valid[v.k] = 1'b1;
      for (int i = 0; i < n; i++) begin
         step();
         if (v.toggle) begin
            data[v.k]  = 9'($urandom);
            valid[v.k] = (i < n - 2) ? 1'($urandom) : 1'b0;
         end else if (i == 0) begin
            valid[v.k] = 1'b0;
         end
      end
   endtask

   initial begin
      int   nb;
      int   falls[$];
      logic prev;
      vec_t v;

      vecs[0] = '{0, 9'h0A5, ParEn ? 16'h054A : 16'h034A, 10 + P, 1'b0};
      vecs[1] = '{3, 9'h0A5, ParEn ? 16'h074A : 16'h034A, 10 + P, 1'b0};
      vecs[2] = '{2, 9'h013, ParEn ? 16'h00E6 : 16'h0066, 7 + P, 1'b0};
      vecs[3] = '{0, 9'h05A, ParEn ? 16'h04B4 : 16'h02B4, 10 + P, 1'b1};
      vecs[4] = '{1, 9'h001, ParEn ? 16'h0E02 : 16'h0602, 11 + P, 1'b0};
      vecs[5] = '{2, 9'h01F, ParEn ? 16'h00FE : 16'h007E, 7 + P, 1'b1};
      vecs[6] = '{0, 9'h0FF, ParEn ? 16'h05FE : 16'h03FE, 10 + P, 1'b1};
      vecs[7] = '{3, 9'h000, ParEn ? 16'h0600 : 16'h0200, 10 + P, 1'b0};

      // Reset takes effect before any clock edge.
      #1 RESET = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         cur = k;
         check("rst_tx", tx[k], 1'b1);
         check("rst_ready", ready[k], 1'b0);
         check("rst_busy", busy[k], 1'b0);
      end
      @(negedge CLK);
      cur = 0;
      check("rst_hold_ready", ready[0], 1'b0);
      RESET = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cur = k;
         exp_q.push_back('{1'b1, 1'b0, 1'b1});
         step();
      end

      // Table-driven single frames.
      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // Back-to-back frames with valid held high and two stop bits.
      cur = 1;
      nb  = 11 + P;
      push_frame(ParEn ? 16'h0C00 : 16'h0600, nb, 4);
      push_frame(ParEn ? 16'h0DFE : 16'h07FE, nb, 4);
      data[1]  = 9'h000;
      valid[1] = 1'b1;
      prev     = 1'b1;
      for (int i = 0; i < 2 * (nb * 4 + 1); i++) begin
         step();
         if (prev && !tx[1]) falls.push_back(i);
         prev = tx[1];
         if (i == 0) data[1] = 9'h0FF;
         if (i == nb * 4 + 1) valid[1] = 1'b0;
      end
      check_int("b2b_starts", falls.size(), 2);
      if (falls.size() == 2) check_int("b2b_period", falls[1] - falls[0], ParEn ? 49 : 45);

      // Reset in the middle of the payload of 0x3C, then a clean 0x81 frame.
      cur = 0;
      push_frame(ParEn ? 16'h0478 : 16'h0278, 10 + P, 4);
      data[0]  = 9'h03C;
      valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         valid[0] = 1'b0;
      end
      check("pre_abort_tx", tx[0], 1'b0);
      #2 RESET = 1'b1;
      #1;
      check("abort_tx", tx[0], 1'b1);
      check("abort_busy", busy[0], 1'b0);
      check("abort_ready", ready[0], 1'b0);
      exp_q.delete();
      @(negedge CLK);
      check("abort_hold_tx", tx[0], 1'b1);
      RESET = 1'b0;
      exp_q.push_back('{1'b1, 1'b0, 1'b1});
      step();
      v = '{0, 9'h081, ParEn ? 16'h0502 : 16'h0302, 10 + P, 1'b0};
      run_vec(v);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: CLK cycles per bit period; must be at least 1.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined.
REQ-005 SHALL have port CLK, input, 1 bit: clock; all state changes on the rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port data, input, DATA_W bits: payload, sampled only on handshake.
REQ-008 SHALL have port valid, input, 1 bit: producer offers data.
REQ-009 SHALL have port ready, output, 1 bit: block can accept data.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in flight.

Function
REQ-012 SHALL drive ready, tx and busy from registers only, with no combinational path from any input.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-014 SHALL define the handshake as valid && ready on a rising edge, and SHALL assert ready only in IDLE.
REQ-015 SHALL capture data into an internal shift register on handshake, and SHALL ignore changes on data or valid at all other times.
REQ-016 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, timed by a divider that restarts at the start of every frame.
REQ-017 SHALL send the frame in this order: start bit (0), then DATA_W bits LSB first, then the parity bit if enabled, then STOP_BITS stop bits (1).
REQ-018 SHALL drive tx to 0 in the first cycle after the handshake edge, so latency from handshake to start bit is 1 cycle.
REQ-019 SHALL make the frame length F = (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
REQ-020 SHALL move the FSM to IDLE after the last stop-bit cycle, with ready=1 and tx=1.
REQ-021 SHALL, with valid held high, give back-to-back frames a period of exactly F+1 cycles, including one idle cycle at tx=1.
REQ-022 SHALL assert busy in every state except IDLE, so that busy equals the inverse of ready.
REQ-023 SHALL use a bit counter of width $clog2(DATA_W) with no wrap-around: DATA exits after exactly DATA_W bits.
REQ-024 SHALL, when CLKS_PER_BIT=1, advance one bit per cycle with no divider stall.
REQ-025 SHALL not accept valid while in a non-IDLE state, and SHALL not drop or duplicate any frame.

Reset
REQ-026 SHALL, while RESET is high, force tx=1, ready=0, busy=0, state IDLE and zero the divider, bit counter and shift register, without waiting for a clock edge.
REQ-027 SHALL abort any frame in progress when RESET is asserted mid-frame, with no resumption; tx returns high immediately.
REQ-028 SHALL assert ready=1 on the first rising CLK edge after RESET deasserts.

Configuration
REQ-029 SHALL use macro UART_TX_PARITY_EN: when defined, SHALL insert a PARITY state sending XOR of the payload bits, inverted when PARITY_ODD=1.
REQ-030 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or parity logic, and SHALL go straight from DATA to STOP.

Structure
REQ-031 SHALL take the FSM state enum typedef and the parity-mode constants from shared package uart_pkg.
REQ-032 SHALL implement the bit-period divider as sub-module uart_baud_tick, with parameter CLKS_PER_BIT and ports CLK, RESET, clear and tick.

Verification
REQ-033 SHALL check, with defaults and no parity, that data=0xA5 plus a valid pulse gives tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; F=40; ready returns high at cycle 41.
REQ-034 SHALL check, with UART_TX_PARITY_EN and PARITY_ODD=0, that data=0xA5 gives a parity bit of 0; with PARITY_ODD=1 it gives 1; F=44.
REQ-035 SHALL check, with STOP_BITS=2 and valid held high carrying 0x00 then 0xFF, that each frame has two stop bits (8 cycles of tx=1), the frames are 45 cycles apart, and both frames arrive intact.
REQ-036 SHALL check that asserting RESET mid-DATA for 0x3C drives tx=1 and busy=0 at once, and that a new frame for 0x81 after release is correct.
REQ-037 SHALL check, with CLKS_PER_BIT=1 and DATA_W=5, that data=0x13 gives tx = 0,1,1,0,0,1,1 over 7 cycles.
REQ-038 SHALL check that toggling data during a frame does not change the transmitted bits.
